// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLLVR dynamic retune controller.
package pll_ctrl_pkg;

  localparam int PLL_SEL_W = 6;
  localparam int LOSS_W    = 8;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERR    = 3'd4
  } pll_state_e;

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL LOCK into the clkin domain.
module lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_retune_ctrl.sv
// Retune/relock sequencer for a PLLVR: holds RESET, waits for a stable LOCK, relocks on loss.
// Optional lock-loss counter is built only when PLL_LOSS_CNT_EN is defined.
module pll_retune_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 27000,
  parameter int unsigned LOCK_STABLE  = 64
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PLL_SEL_W-1:0] req_idsel,
  input  logic [PLL_SEL_W-1:0] req_fbdsel,
  input  logic [PLL_SEL_W-1:0] req_odsel,
  output logic [PLL_SEL_W-1:0] pll_idsel,
  output logic [PLL_SEL_W-1:0] pll_fbdsel,
  output logic [PLL_SEL_W-1:0] pll_odsel,
  output logic                 pll_reset,
  input  logic                 pll_lock,
  output logic                 locked,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [LOSS_W-1:0]    loss_cnt,
  output pll_state_e           dbg_state
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);

  pll_state_e           state_q, state_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [STB_W-1:0]     stb_cnt_q, stb_cnt_d;
  logic [PLL_SEL_W-1:0] idsel_q, idsel_d;
  logic [PLL_SEL_W-1:0] fbdsel_q, fbdsel_d;
  logic [PLL_SEL_W-1:0] odsel_q, odsel_d;
  logic                 lock_s;
  logic                 accept;
  logic                 tmo_expired;

  lock_sync u_lock_sync (
    .clk_i (clkin),
    .rst_i (reset),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  // Handshake: req_ready is high only in RUN or ERR; a request is taken on any
  // rising clkin edge where req_valid && req_ready, codes are captured on that edge.
  assign req_ready   = (state_q == ST_RUN) || (state_q == ST_ERR);
  assign accept      = req_valid && req_ready;
  assign tmo_expired = tmo_cnt_q >= TMO_W'(LOCK_TIMEOUT - 1);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    stb_cnt_d = stb_cnt_q;
    idsel_d   = idsel_q;
    fbdsel_d  = fbdsel_q;
    odsel_d   = odsel_q;

    case (state_q)
      ST_HOLD: begin
        if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
          state_d   = ST_WAIT;
          rst_cnt_d = '0;
          tmo_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (lock_s) begin
          state_d   = ST_STABLE;
          stb_cnt_d = '0;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_STABLE: begin
        // Timeout keeps running across lock glitches; only a clean run reaches RUN.
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (lock_s && (stb_cnt_q == STB_W'(LOCK_STABLE - 1))) begin
          state_d = ST_RUN;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end else if (!lock_s) begin
          state_d   = ST_WAIT;
          stb_cnt_d = '0;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d   = ST_HOLD;
          rst_cnt_d = '0;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d   = ST_HOLD;
        rst_cnt_d = '0;
      end
    endcase

    if (accept) begin
      state_d   = ST_HOLD;
      rst_cnt_d = '0;
      idsel_d   = req_idsel;
      fbdsel_d  = req_fbdsel;
      odsel_d   = req_odsel;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q   <= ST_HOLD;
      rst_cnt_q <= '0;
      tmo_cnt_q <= '0;
      stb_cnt_q <= '0;
      idsel_q   <= '0;
      fbdsel_q  <= '0;
      odsel_q   <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      idsel_q   <= idsel_d;
      fbdsel_q  <= fbdsel_d;
      odsel_q   <= odsel_d;
    end
  end

`ifdef PLL_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_cnt_q;
  logic              loss_evt;

  // A loss in RUN counts even when a request is accepted on the same edge.
  assign loss_evt = (state_q == ST_RUN) && !lock_s;

  always_ff @(posedge clkin) begin
    if (reset) begin
      loss_cnt_q <= '0;
    end else if (loss_evt && (loss_cnt_q != {LOSS_W{1'b1}})) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign loss_cnt = loss_cnt_q;
`else
  assign loss_cnt = '0;
`endif

  assign pll_idsel   = idsel_q;
  assign pll_fbdsel  = fbdsel_q;
  assign pll_odsel   = odsel_q;
  assign pll_reset   = (state_q == ST_HOLD) || (state_q == ST_ERR);
  assign locked      = (state_q == ST_RUN);
  assign busy        = (state_q == ST_HOLD) || (state_q == ST_WAIT) || (state_q == ST_STABLE);
  assign err_timeout = (state_q == ST_ERR);
  assign dbg_state   = state_q;

endmodule

// File: doc/pll_retune_ctrl.md
PLL_RETUNE_CTRL -- requirements
Module: pll_retune_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, meaning the number of cycles pll_reset is held high per (re)lock attempt (min 2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 27000, meaning the cycles allowed after pll_reset release for lock to stabilise (1 ms at 27 MHz).
REQ-003 SHALL have parameter LOCK_STABLE, default 64, meaning the consecutive synced-lock-high cycles required before declaring locked.
REQ-004 SHALL have port clkin, input, 1 bit: the single clock (27 MHz oscillator, not PLL output).
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports req_valid (input, 1), req_ready (output, 1): the retune request handshake.
REQ-007 SHALL have ports req_idsel, req_fbdsel, req_odsel, each input, 6 bits: the requested dynamic divider codes.
REQ-008 SHALL have ports pll_idsel, pll_fbdsel, pll_odsel, each output, 6 bits: registered codes driving PLLVR IDSEL/FBDSEL/ODSEL.
REQ-009 SHALL have port pll_reset, output, 1 bit: drives PLLVR RESET.
REQ-010 SHALL have port pll_lock, input, 1 bit: PLLVR LOCK, asynchronous to clkin.
REQ-011 SHALL have ports locked, busy, err_timeout, each output, 1 bit; and loss_cnt, output, 8 bits.

Function
REQ-012 SHALL synchronise pll_lock through two flops (lock_s); all decisions use lock_s only.
REQ-013 SHALL implement states HOLD, WAIT, STABLE, RUN, ERR.
REQ-014 HOLD: pll_reset=1; count RST_CYCLES cycles, then go to WAIT with the timeout counter cleared.
REQ-015 WAIT: pll_reset=0; timeout counter increments each cycle; lock_s=1 -> STABLE with the stable counter cleared; counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> ERR.
REQ-016 STABLE: the timeout counter continues to run; the stable counter increments while lock_s=1; reaching LOCK_STABLE-1 -> RUN; lock_s=0 -> WAIT, with the stable counter cleared and the timeout not reset; timeout expiry -> ERR.
REQ-017 RUN: locked=1; lock_s falling -> HOLD (automatic relock), locked=0 on the next edge, and loss_cnt increments.
REQ-018 ERR: err_timeout=1; pll_reset held 1; remains in ERR until a request is accepted.
REQ-019 req_ready SHALL be 1 only in RUN or ERR; a request is accepted when req_valid&&req_ready on a clock edge.
REQ-020 On acceptance, the request codes SHALL load into pll_*sel on the same edge, the FSM enters HOLD, and err_timeout clears.
REQ-021 If lock loss and request acceptance occur in the same RUN cycle, the request SHALL be accepted (codes loaded) and loss_cnt SHALL still increment.
REQ-022 busy SHALL equal 1 in HOLD, WAIT and STABLE, and 0 otherwise.
REQ-023 pll_*sel SHALL change only on request acceptance, never during HOLD/WAIT/STABLE.
REQ-024 loss_cnt SHALL saturate at 255 and not wrap.

Reset
REQ-025 On reset: FSM=HOLD, counters=0, pll_reset=1, pll_*sel=0, locked=0, err_timeout=0, loss_cnt=0, sync flops=0, req_ready=0, busy=1.
REQ-026 Reset asserted mid-operation SHALL abandon the sequence and restart from HOLD; pll_*sel return to 0 (the static PLL configuration).

Configuration
REQ-027 Macro PLL_LOSS_CNT_EN: when defined, loss_cnt SHALL behave per REQ-017/021/024.
REQ-028 When PLL_LOSS_CNT_EN is undefined, loss_cnt SHALL be constant 0 and its counter logic SHALL be omitted.

Structure
REQ-029 Package pll_ctrl_pkg SHALL hold the state enum type and the constant PLL_SEL_W=6.
REQ-030 Sub-module lock_sync (two-flop synchroniser) SHALL be used for pll_lock.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8)
REQ-031 Reset release, pll_lock=1 constant:
- pll_reset high for 4 cycles, then low.
- locked=1 after 2 sync cycles + 8 stable cycles; req_ready=1.
REQ-032 In RUN, request codes 3/8/32 with req_valid=1:
- pll_*sel=3/8/32 next edge; busy=1; pll_reset high 4 cycles.
- locked=1 again once lock stays high for 8 cycles.
REQ-033 pll_lock held 0 after reset:
- err_timeout=1 after 4+100 cycles; pll_reset=1; req_ready=1.
- A new request clears err_timeout.
REQ-034 In STABLE, pll_lock glitches low for 1 cycle at stable count 5:
- Returns to WAIT; locked only after 8 fresh consecutive stable cycles.
- ERR if 100 cycles total elapse first.
REQ-035 In RUN, drop pll_lock 300 times with relock after each:
- loss_cnt=255 (saturated) with PLL_LOSS_CNT_EN defined; 0 without it.
REQ-036 Assert reset in WAIT:
- Next cycle: FSM=HOLD, pll_*sel=0, pll_reset=1, locked=0.
